// File: rtl/riscv_pkg.sv
// Immediate-format select codes and default datapath width shared by the
// decoder, the immediate generator and the ID/EX operand muxes.
package riscv_pkg;

    localparam int XLEN_DEF = 64;

    localparam logic [3:0] IMM_I     = 4'b0000;
    localparam logic [3:0] IMM_U     = 4'b0001;
    localparam logic [3:0] IMM_J     = 4'b0010;
    localparam logic [3:0] IMM_S     = 4'b0011;
    localparam logic [3:0] IMM_B     = 4'b0100;
    localparam logic [3:0] IMM_Z     = 4'b0101;
    localparam logic [3:0] IMM_SHAMT = 4'b0110;
    localparam logic [3:0] IMM_CI    = 4'b1000;
    localparam logic [3:0] IMM_CJ    = 4'b1001;
    localparam logic [3:0] IMM_CB    = 4'b1010;

endpackage

// File: rtl/riscv_immgen_comb.sv
// Combinational immediate decode for all base, CSR, shift and RVC formats.
// Zero latency, no flow control; illegal flags codes this build cannot decode.
module riscv_immgen_comb
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter bit RVC_EN = 1'b1
) (
    input  logic [3:0]      immsrc,
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] simm,
    output logic            illegal
);

    // Every format fits a 32-bit value; zero-extended formats keep bit 31 clear,
    // so one final sign extension to XLEN serves them all.
    logic [31:0] imm32;
    logic        unused_inst;

    assign unused_inst = ^inst[1:0];

    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (immsrc)
            IMM_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_U: imm32 = {inst[31:12], 12'b0};
            IMM_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                            inst[30:21], 1'b0};
            IMM_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                            inst[11:8], 1'b0};
            IMM_Z: imm32 = {27'b0, inst[19:15]};
            IMM_SHAMT: begin
                if (XLEN == 64) imm32 = {26'b0, inst[25:20]};
                else            imm32 = {27'b0, inst[24:20]};
            end
            IMM_CI: begin
                if (RVC_EN) imm32 = {{26{inst[12]}}, inst[12], inst[6:2]};
                else        illegal = 1'b1;
            end
            IMM_CJ: begin
                if (RVC_EN) imm32 = {{20{inst[12]}}, inst[12], inst[8], inst[10:9],
                                     inst[6], inst[7], inst[2], inst[11],
                                     inst[5:3], 1'b0};
                else        illegal = 1'b1;
            end
            IMM_CB: begin
                if (RVC_EN) imm32 = {{23{inst[12]}}, inst[12], inst[6:5], inst[2],
                                     inst[11:10], inst[4:3], 1'b0};
                else        illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign simm = {{32{imm32[31]}}, imm32};
        end else begin : g_x32
            assign simm = imm32;
        end
    endgenerate

endmodule

// File: rtl/riscv_immgen_pipe.sv
// Registered immediate generator at the decode/execute boundary; 1-cycle latency.
// Single-entry valid/ready stage: ready when empty or draining, flush kills held and incoming item.
module riscv_immgen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter bit RVC_EN = 1'b1,
    parameter int TAG_W  = 5
) (
    input  logic             i_riscv_immgen_clk,
    input  logic             i_riscv_immgen_rst,
    input  logic             i_riscv_immgen_valid,
    output logic             o_riscv_immgen_ready,
    input  logic [3:0]       i_riscv_immgen_immsrc,
    input  logic [31:0]      i_riscv_immgen_inst,
    input  logic [TAG_W-1:0] i_riscv_immgen_tag,
    input  logic             i_riscv_immgen_flush,
    output logic             o_riscv_immgen_valid,
    input  logic             i_riscv_immgen_ready,
    output logic [XLEN-1:0]  o_riscv_immgen_simm,
    output logic [TAG_W-1:0] o_riscv_immgen_tag,
    output logic             o_riscv_immgen_illegal
);

    logic [XLEN-1:0] dec_simm;
    logic            dec_illegal;
    logic            accept;

    riscv_immgen_comb #(
        .XLEN   (XLEN),
        .RVC_EN (RVC_EN)
    ) u_dec (
        .immsrc  (i_riscv_immgen_immsrc),
        .inst    (i_riscv_immgen_inst),
        .simm    (dec_simm),
        .illegal (dec_illegal)
    );

    assign o_riscv_immgen_ready = !o_riscv_immgen_valid | i_riscv_immgen_ready;

    // A flushed cycle never loads data, so held outputs stay untouched by killed items.
    assign accept = i_riscv_immgen_valid & o_riscv_immgen_ready & !i_riscv_immgen_flush;

    always_ff @(posedge i_riscv_immgen_clk or posedge i_riscv_immgen_rst) begin
        if (i_riscv_immgen_rst) begin
            o_riscv_immgen_valid <= 1'b0;
        end else if (i_riscv_immgen_flush) begin
            o_riscv_immgen_valid <= 1'b0;
        end else if (accept) begin
            o_riscv_immgen_valid <= 1'b1;
        end else if (i_riscv_immgen_ready) begin
            o_riscv_immgen_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_riscv_immgen_clk or posedge i_riscv_immgen_rst) begin
        if (i_riscv_immgen_rst) begin
            o_riscv_immgen_simm    <= '0;
            o_riscv_immgen_tag     <= '0;
            o_riscv_immgen_illegal <= 1'b0;
        end else if (accept) begin
            o_riscv_immgen_simm    <= dec_simm;
            o_riscv_immgen_tag     <= i_riscv_immgen_tag;
            o_riscv_immgen_illegal <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_riscv_immgen_pipe.sv
// Bench for riscv_immgen_pipe: XLEN=64/RVC, XLEN=32/RVC and XLEN=64/no-RVC builds share stimulus.
module tb_riscv_immgen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_vld = 1'b0;
    logic [3:0]  in_src = '0;
    logic [31:0] in_inst = '0;
    logic [4:0]  in_tag = '0;
    logic        in_flush = 1'b0;
    logic        dn_rdy = 1'b0;

    logic        r64, r32, rnr;
    logic        v64, v32, vnr;
    logic [63:0] s64, snr;
    logic [31:0] s32;
    logic [4:0]  t64, t32, tnr;
    logic        il64, il32, ilnr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_immgen_pipe #(.XLEN(64), .RVC_EN(1'b1), .TAG_W(5)) dut (
        .i_riscv_immgen_clk(clk), .i_riscv_immgen_rst(rst),
        .i_riscv_immgen_valid(in_vld), .o_riscv_immgen_ready(r64),
        .i_riscv_immgen_immsrc(in_src), .i_riscv_immgen_inst(in_inst),
        .i_riscv_immgen_tag(in_tag), .i_riscv_immgen_flush(in_flush),
        .o_riscv_immgen_valid(v64), .i_riscv_immgen_ready(dn_rdy),
        .o_riscv_immgen_simm(s64), .o_riscv_immgen_tag(t64),
        .o_riscv_immgen_illegal(il64));

    riscv_immgen_pipe #(.XLEN(32), .RVC_EN(1'b1), .TAG_W(5)) dut32 (
        .i_riscv_immgen_clk(clk), .i_riscv_immgen_rst(rst),
        .i_riscv_immgen_valid(in_vld), .o_riscv_immgen_ready(r32),
        .i_riscv_immgen_immsrc(in_src), .i_riscv_immgen_inst(in_inst),
        .i_riscv_immgen_tag(in_tag), .i_riscv_immgen_flush(in_flush),
        .o_riscv_immgen_valid(v32), .i_riscv_immgen_ready(dn_rdy),
        .o_riscv_immgen_simm(s32), .o_riscv_immgen_tag(t32),
        .o_riscv_immgen_illegal(il32));

    riscv_immgen_pipe #(.XLEN(64), .RVC_EN(1'b0), .TAG_W(5)) dutnr (
        .i_riscv_immgen_clk(clk), .i_riscv_immgen_rst(rst),
        .i_riscv_immgen_valid(in_vld), .o_riscv_immgen_ready(rnr),
        .i_riscv_immgen_immsrc(in_src), .i_riscv_immgen_inst(in_inst),
        .i_riscv_immgen_tag(in_tag), .i_riscv_immgen_flush(in_flush),
        .o_riscv_immgen_valid(vnr), .i_riscv_immgen_ready(dn_rdy),
        .o_riscv_immgen_simm(snr), .o_riscv_immgen_tag(tnr),
        .o_riscv_immgen_illegal(ilnr));

    typedef struct {
        logic [3:0]  src;
        logic [31:0] inst;
        logic [63:0] e64;
        logic [31:0] e32;
        logic        ill;
        logic [63:0] enr;
        logic        ill_nr;
    } vec_t;

    typedef struct {
        logic [63:0] e64;
        logic [63:0] e32;
        logic [63:0] enr;
        logic        i64;
        logic        i32;
        logic        inr;
        logic [4:0]  tag;
    } item_t;

    item_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic [31:0] ins,
                         input logic [4:0] t, input logic r, input logic f);
        in_vld = v; in_src = s; in_inst = ins; in_tag = t; dn_rdy = r; in_flush = f;
    endtask

    task automatic chk_valid(input string name, input logic exp);
        chk({name, ".valid64"}, {63'b0, v64}, {63'b0, exp});
        chk({name, ".valid32"}, {63'b0, v32}, {63'b0, exp});
        chk({name, ".validnr"}, {63'b0, vnr}, {63'b0, exp});
    endtask

    task automatic chk_data(input string name, input item_t it);
        chk({name, ".simm64"}, s64, it.e64);
        chk({name, ".simm32"}, {32'b0, s32}, it.e32);
        chk({name, ".simmnr"}, snr, it.enr);
        chk({name, ".ill64"}, {63'b0, il64}, {63'b0, it.i64});
        chk({name, ".ill32"}, {63'b0, il32}, {63'b0, it.i32});
        chk({name, ".illnr"}, {63'b0, ilnr}, {63'b0, it.inr});
        chk({name, ".tag64"}, {59'b0, t64}, {59'b0, it.tag});
        chk({name, ".tag32"}, {59'b0, t32}, {59'b0, it.tag});
        chk({name, ".tagnr"}, {59'b0, tnr}, {59'b0, it.tag});
    endtask

    task automatic chk_ready(input string name, input logic exp);
        chk({name, ".ready64"}, {63'b0, r64}, {63'b0, exp});
        chk({name, ".ready32"}, {63'b0, r32}, {63'b0, exp});
        chk({name, ".readynr"}, {63'b0, rnr}, {63'b0, exp});
    endtask

    // Reference: assemble the raw field value, then sign-extend with arithmetic.
    function automatic logic [63:0] ref_imm(input logic [3:0] src, input logic [31:0] inst,
                                            input int xlen, input bit rvc, output logic ill);
        longint u = longint'({32'b0, inst});
        longint v = 0;
        int w = 0;
        logic [63:0] r;
        ill = 1'b0;
        case (src)
            4'd0: begin v = u >> 20; w = 12; end
            4'd1: begin v = (u >> 12) << 12; w = 32; end
            4'd2: begin v = (((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12)
                          | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1); w = 21; end
            4'd3: begin v = ((u >> 25) << 5) | ((u >> 7) & 31); w = 12; end
            4'd4: begin v = (((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11)
                          | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1); w = 13; end
            4'd5: v = (u >> 15) & 31;
            4'd6: v = (u >> 20) & ((xlen == 64) ? 63 : 31);
            4'd8: begin v = (((u >> 12) & 1) << 5) | ((u >> 2) & 31); w = 6; end
            4'd9: begin v = (((u >> 12) & 1) << 11) | (((u >> 8) & 1) << 10)
                          | (((u >> 9) & 3) << 8) | (((u >> 6) & 1) << 7)
                          | (((u >> 7) & 1) << 6) | (((u >> 2) & 1) << 5)
                          | (((u >> 11) & 1) << 4) | (((u >> 3) & 7) << 1); w = 12; end
            4'd10: begin v = (((u >> 12) & 1) << 8) | (((u >> 5) & 3) << 6)
                           | (((u >> 2) & 1) << 5) | (((u >> 10) & 3) << 3)
                           | (((u >> 3) & 3) << 1); w = 9; end
            default: ill = 1'b1;
        endcase
        if (src >= 4'd8 && src <= 4'd10 && !rvc) begin
            ill = 1'b1;
            v = 0;
        end
        if (w > 0 && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
        r = 64'(v);
        if (xlen == 32) r = {32'b0, r[31:0]};
        return r;
    endfunction

    vec_t tbl[15];
    item_t cur;

    initial begin
        tbl[0]  = '{4'b0000, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        tbl[1]  = '{4'b0001, 32'h12345037, 64'h0000000012345000, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
        tbl[2]  = '{4'b0100, 32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        tbl[3]  = '{4'b0101, 32'h34029073, 64'h5, 32'h5, 1'b0, 64'h5, 1'b0};
        tbl[4]  = '{4'b0010, 32'h8000006F, 64'hFFFFFFFFFFF00000, 32'hFFF00000, 1'b0, 64'hFFFFFFFFFFF00000, 1'b0};
        tbl[5]  = '{4'b0011, 32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        tbl[6]  = '{4'b0110, 32'h03F0D093, 64'h3F, 32'h1F, 1'b0, 64'h3F, 1'b0};
        tbl[7]  = '{4'b0110, 32'h01F0D093, 64'h1F, 32'h1F, 1'b0, 64'h1F, 1'b0};
        tbl[8]  = '{4'b0000, 32'h80000093, 64'hFFFFFFFFFFFFF800, 32'hFFFFF800, 1'b0, 64'hFFFFFFFFFFFFF800, 1'b0};
        tbl[9]  = '{4'b1001, 32'h0000BFFD, 64'hFFFFFFFFFFFFFFFE, 32'hFFFFFFFE, 1'b0, 64'h0, 1'b1};
        tbl[10] = '{4'b1000, 32'h00005FFD, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h0, 1'b1};
        tbl[11] = '{4'b1010, 32'h0000DC7D, 64'hFFFFFFFFFFFFFFFE, 32'hFFFFFFFE, 1'b0, 64'h0, 1'b1};
        tbl[12] = '{4'b0111, 32'h12345678, 64'h0, 32'h0, 1'b1, 64'h0, 1'b1};
        tbl[13] = '{4'b1111, 32'hFFFFFFFF, 64'h0, 32'h0, 1'b1, 64'h0, 1'b1};
        tbl[14] = '{4'b1011, 32'hFFFFFFFF, 64'h0, 32'h0, 1'b1, 64'h0, 1'b1};

        // Reset state, including o_ready while reset is held.
        #1 rst = 1'b1;
        #2;
        chk_valid("reset", 1'b0);
        cur = '{64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 5'h0};
        chk_data("reset", cur);
        chk_ready("reset", 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors issued back-to-back; each result is checked the next cycle.
        for (int i = 0; i <= 15; i++) begin
            if (i < 15) drive(1'b1, tbl[i].src, tbl[i].inst, 5'(i), 1'b1, 1'b0);
            else        drive(1'b0, 4'b0, 32'h0, 5'h0, 1'b1, 1'b0);
            if (i > 0) begin
                cur = '{tbl[i-1].e64, {32'b0, tbl[i-1].e32}, tbl[i-1].enr,
                        tbl[i-1].ill, tbl[i-1].ill, tbl[i-1].ill_nr, 5'(i-1)};
                chk_valid($sformatf("vec%0d", i-1), 1'b1);
                chk_data($sformatf("vec%0d", i-1), cur);
            end
            @(negedge clk);
        end
        chk_valid("drain", 1'b0);

        // Backpressure: J item held for 4 stalled cycles while a B item waits.
        drive(1'b1, 4'b0010, 32'h8000006F, 5'h11, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 4'b0100, 32'hFE000EE3, 5'h12, 1'b0, 1'b0);
        cur = '{64'hFFFFFFFFFFF00000, 64'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0, 1'b0, 1'b0, 5'h11};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_valid($sformatf("stall%0d", k), 1'b1);
            chk_data($sformatf("stall%0d", k), cur);
            chk_ready($sformatf("stall%0d", k), 1'b0);
            @(negedge clk);
        end
        dn_rdy = 1'b1;
        #1 chk_ready("release", 1'b1);
        chk_data("release_hold", cur);
        @(negedge clk);
        drive(1'b0, 4'b0, 32'h0, 5'h0, 1'b1, 1'b0);
        cur = '{64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0, 1'b0, 5'h12};
        chk_valid("after_release", 1'b1);
        chk_data("after_release", cur);
        @(negedge clk);
        chk_valid("after_release_drain", 1'b0);

        // Flush with a held item, downstream stalled and a new item offered.
        drive(1'b1, 4'b0000, 32'hFFF00093, 5'h03, 1'b0, 1'b0);
        @(negedge clk);
        chk_valid("pre_flush", 1'b1);
        drive(1'b1, 4'b0001, 32'h12345037, 5'h04, 1'b0, 1'b1);
        @(negedge clk);
        chk_valid("flush", 1'b0);
        drive(1'b0, 4'b0, 32'h0, 5'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk_valid("flush_dropped", 1'b0);

        // Asynchronous reset while an illegal item is stalled.
        drive(1'b1, 4'b1111, 32'h0, 5'h07, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'b0, 32'h0, 5'h0, 1'b0, 1'b0);
        chk_valid("pre_areset", 1'b1);
        chk("pre_areset.ill64", {63'b0, il64}, 64'h1);
        #2 rst = 1'b1;
        #1;
        chk_valid("areset", 1'b0);
        cur = '{64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 5'h0};
        chk_data("areset", cur);
        chk_ready("areset", 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic against the reference model and a one-deep scoreboard.
        q.delete();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            chk_valid("rnd", q.size() != 0);
            if (q.size() != 0) chk_data("rnd", q[0]);
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
                  5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0);
            #1 chk_ready("rnd", q.size() == 0 || dn_rdy);
            @(posedge clk);
            if (in_flush) begin
                q.delete();
            end else begin
                logic take;
                take = in_vld && (q.size() == 0 || dn_rdy);
                if (q.size() != 0 && dn_rdy) void'(q.pop_front());
                if (take) begin
                    item_t it;
                    it.e64 = ref_imm(in_src, in_inst, 64, 1'b1, it.i64);
                    it.e32 = ref_imm(in_src, in_inst, 32, 1'b1, it.i32);
                    it.enr = ref_imm(in_src, in_inst, 64, 1'b0, it.inr);
                    it.tag = in_tag;
                    q.push_back(it);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_immgen_pipe.md
Name: riscv_immgen_pipe

Overview:
- Parametrised, registered immediate generator for the decode/execute boundary.
- Generalises the combinational extender:
  - XLEN-wide output (32 or 64).
  - Adds CSR-zimm, shift-amount and optional RVC formats.
  - One-entry valid/ready pipeline register with stall and flush.
- Sits between the instruction decoder (which supplies raw instruction bits and format select) and the ID/EX operand muxes.

Parameters:
- XLEN, 64, output width; legal values 32 or 64.
- RVC_EN, 1, 1 = compressed formats 1000–1010 decoded; 0 = those codes are illegal.
- TAG_W, 5, width of the sideband tag (e.g. rd index) carried alongside the immediate.

Ports:
- i_riscv_immgen_clk  in  1  clock, rising edge.
- i_riscv_immgen_rst  in  1  reset, asynchronous, active-high.
- i_riscv_immgen_valid  in  1  upstream has an instruction.
- o_riscv_immgen_ready  out  1  block can accept this cycle.
- i_riscv_immgen_immsrc  in  4  format select (encoding below).
- i_riscv_immgen_inst  in  32  raw instruction; for RVC the 16-bit parcel is in [15:0].
- i_riscv_immgen_tag  in  TAG_W  sideband, passed through unchanged.
- i_riscv_immgen_flush  in  1  kill held and incoming instruction.
- o_riscv_immgen_valid  out  1  registered result valid.
- i_riscv_immgen_ready  in  1  downstream accepts.
- o_riscv_immgen_simm  out  XLEN  extended immediate.
- o_riscv_immgen_tag  out  TAG_W  registered tag.
- o_riscv_immgen_illegal  out  1  registered: immsrc unsupported.

Behaviour:
- Format encoding (s = sign-extended to XLEN, z = zero-extended):
  - 0000 I: s(inst[31:20]).
  - 0001 U: s({inst[31:12], 12'b0}).
  - 0010 J: s({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - 0011 S: s({inst[31:25], inst[11:7]}).
  - 0100 B: s({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - 0101 Z (CSR uimm): z(inst[19:15]).
  - 0110 SHAMT: z(inst[25:20]) when XLEN=64; z(inst[24:20]) when XLEN=32.
  - 1000 CI: s({inst[12], inst[6:2]}).
  - 1001 CJ: s({inst[12], inst[8], inst[10:9], inst[6], inst[7], inst[2], inst[11], inst[5:3], 0}).
  - 1010 CB: s({inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 0}).
  - All other codes, and 1000–1010 when RVC_EN=0: simm = 0, illegal = 1.
- Handshake:
  - o_ready = !o_valid | i_ready (combinational).
  - Accept when i_valid & o_ready; result, tag and illegal register on that edge.
  - Latency: exactly 1 cycle from accept to o_valid.
- Output register update per edge:
  - If flush: o_valid <= 0, regardless of i_valid or i_ready. Flush has priority over accept.
  - Else if accept: o_valid <= 1, data updated.
  - Else if i_ready: o_valid <= 0.
  - Else hold o_valid and data.
- Data stability: data regs change only on accept. While o_valid=1 and i_ready=0, simm, tag and illegal are stable.
- Back-to-back throughput: 1 per cycle when i_ready stays high.
- Reset (asynchronous assert, any time including mid-stall):
  - o_valid=0, simm=0, tag=0, illegal=0.
  - o_ready reads 1 while in reset.
- No internal state beyond the single output register; no FSM beyond valid/empty.

Decomposition:
- Shared package/header `riscv_pkg`: IMM_I … IMM_CB 4-bit localparams, XLEN default.
- Sub-module `riscv_immgen_comb`: pure combinational format decode (XLEN, RVC_EN parameters; outputs simm and illegal).
- Top holds only the handshake and pipeline register.

Test Plan:
- Reset then I-type: inst 0xFFF00093, immsrc 0000, valid 1 cycle, i_ready=1 → next cycle o_valid=1, simm=0xFFFF_FFFF_FFFF_FFFF, illegal=0.
- Back-to-back, one per cycle:
  - U 0x12345037 → 0x0000_0000_1234_5000.
  - B 0xFE000EE3 → 0xFFFF_FFFF_FFFF_FFFC.
  - Z 0x34029073 → 0x5.
  - Check o_valid held high 3 consecutive cycles.
- Backpressure:
  - Hold i_ready=0 for 4 cycles with a J-type accepted → simm, tag stable and o_ready=0.
  - A new i_valid is not taken; on release the next item appears the following cycle.
- Flush:
  - Assert flush with o_valid=1, i_ready=0 and i_valid=1 → next cycle o_valid=0; the incoming item is dropped.
- RVC / illegal:
  - RVC_EN=1: c.j 0xBFFD, immsrc 1001 → simm=−2.
  - immsrc 1111 → simm=0, illegal=1.
  - RVC_EN=0 build with immsrc 1001 → illegal=1.
- XLEN=32 build:
  - SHAMT inst 0x01F0D093 → simm=0x1F.
  - I 0x80000093 → 0xFFFF_F800.
  - Async reset pulsed mid-stall → o_valid drops immediately without waiting for a clock edge.
